// File: rtl/vjtag_count_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : vjtag_count_sequencer                                           |
// | Brief  : Virtual-JTAG command FIFO and sequencer for an 8-bit counter,   |
// |          with round-robin sharing against a local increment requester.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module vjtag_count_sequencer #(
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         tck,
    input  logic         aclr,
    input  logic         tdi,
    input  logic [1:0]   ir_in,
    input  logic         v_cdr,
    input  logic         v_sdr,
    input  logic         v_udr,
    input  logic         local_req,
    output logic         tdo,
    output logic         local_ack,
    output logic [W-1:0] count_out,
    output logic         busy
);
    localparam int             c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_FULL_CNT  = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [W-1:0]   c_ONE       = W'(1);

    localparam logic [1:0] c_IR_BYPASS = 2'b00;
    localparam logic [1:0] c_IR_STATUS = 2'b01;
    localparam logic [1:0] c_IR_CMD    = 2'b10;
    localparam logic [1:0] c_IR_READ   = 2'b11;

    localparam logic [1:0] c_OP_NOP    = 2'b00;
    localparam logic [1:0] c_OP_LOAD   = 2'b01;
    localparam logic [1:0] c_OP_STEP   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR  = 2'b11;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXEC   = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W+1:0]    cmd_q, cmd_d;
    logic            rr_local_q, rr_local_d;
    logic            local_ack_q, local_ack_d;
    logic            ovf_q, drop_q;

    logic [W+1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]   fifo_cnt_q;

    logic            bypass_q;
    logic [7:0]      status_sr_q;
    logic [W-1:0]    read_sr_q;
    logic [W+1:0]    cmd_sr_q;

    logic            w_fifo_empty, w_fifo_full, w_busy;
    logic            w_push_req, w_push, w_pop, w_drop_set;
    logic            w_jtag_pend, w_local_pend;
    logic            w_grant_jtag, w_grant_local;
    logic            w_status_cap, w_ovf_set;
    logic [7:0]      w_status;

    assign w_fifo_empty = (fifo_cnt_q == '0);
    assign w_fifo_full  = (fifo_cnt_q == c_FULL_CNT);
    assign w_busy       = (state_q != c_ST_IDLE) || !w_fifo_empty;
    assign w_jtag_pend  = !w_fifo_empty;
    // The ack cycle blocks a re-grant so a held request cannot count twice.
    assign w_local_pend = local_req && !local_ack_q;
    assign w_pop        = w_grant_jtag;
    assign w_push_req   = v_udr && (ir_in == c_IR_CMD);
    assign w_push       = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop_set   = w_push_req && !w_push;
    assign w_status_cap = v_cdr && (ir_in == c_IR_STATUS);
    assign w_status     = {3'b000, drop_q, ovf_q, w_busy, w_fifo_full, w_fifo_empty};

    // State register
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) state_q <= c_ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and arbitration
    always_comb begin
        state_d       = state_q;
        w_grant_jtag  = 1'b0;
        w_grant_local = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (w_jtag_pend && w_local_pend) begin
                    w_grant_jtag  = rr_local_q;
                    w_grant_local = !rr_local_q;
                end else begin
                    w_grant_jtag  = w_jtag_pend;
                    w_grant_local = w_local_pend;
                end
                if (w_grant_jtag) state_d = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                if (cmd_q[W+1:W] == c_OP_STEP && cmd_q[W-1:0] != '0) state_d = c_ST_RUN;
                else                                                  state_d = c_ST_IDLE;
            end
            c_ST_RUN: begin
                if (rem_q == c_ONE) state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        count_d     = count_q;
        rem_d       = rem_q;
        cmd_d       = cmd_q;
        rr_local_d  = rr_local_q;
        local_ack_d = w_grant_local;
        w_ovf_set   = 1'b0;
        if (w_grant_jtag) begin
            cmd_d      = fifo_mem_q[rd_ptr_q];
            rr_local_d = 1'b0;
        end
        if (w_grant_local) begin
            count_d    = count_q + c_ONE;
            w_ovf_set  = &count_q;
            rr_local_d = 1'b1;
        end
        case (state_q)
            c_ST_EXEC: begin
                case (cmd_q[W+1:W])
                    c_OP_LOAD:  count_d = cmd_q[W-1:0];
                    c_OP_CLEAR: count_d = '0;
                    c_OP_STEP:  rem_d   = cmd_q[W-1:0];
                    default:    count_d = count_q;
                endcase
            end
            c_ST_RUN: begin
                count_d   = count_q + c_ONE;
                rem_d     = rem_q - c_ONE;
                w_ovf_set = &count_q;
            end
            default: rem_d = rem_q;
        endcase
    end

    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            count_q     <= '0;
            rem_q       <= '0;
            cmd_q       <= '0;
            rr_local_q  <= 1'b1;
            local_ack_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            rem_q       <= rem_d;
            cmd_q       <= cmd_d;
            rr_local_q  <= rr_local_d;
            local_ack_q <= local_ack_d;
            // A set coinciding with the STATUS capture wins over the clear.
            ovf_q       <= (ovf_q  && !w_status_cap) || w_ovf_set;
            drop_q      <= (drop_q && !w_status_cap) || w_drop_set;
        end
    end

    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            if (w_push) begin
                fifo_mem_q[wr_ptr_q] <= cmd_sr_q;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!w_push && w_pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    // DR chains: LSB out on tdo, tdi enters at the MSB
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            bypass_q    <= 1'b0;
            status_sr_q <= '0;
            read_sr_q   <= '0;
            cmd_sr_q    <= '0;
        end else if (v_cdr) begin
            case (ir_in)
                c_IR_BYPASS: bypass_q    <= 1'b0;
                c_IR_STATUS: status_sr_q <= w_status;
                c_IR_CMD:    cmd_sr_q    <= '0;
                default:     read_sr_q   <= count_q;
            endcase
        end else if (v_sdr) begin
            case (ir_in)
                c_IR_BYPASS: bypass_q    <= tdi;
                c_IR_STATUS: status_sr_q <= {tdi, status_sr_q[7:1]};
                c_IR_CMD:    cmd_sr_q    <= {tdi, cmd_sr_q[W+1:1]};
                default:     read_sr_q   <= {tdi, read_sr_q[W-1:1]};
            endcase
        end
    end

    always_comb begin
        tdo = 1'b0;
        case (ir_in)
            c_IR_BYPASS: tdo = bypass_q;
            c_IR_STATUS: tdo = status_sr_q[0];
            c_IR_CMD:    tdo = cmd_sr_q[0];
            c_IR_READ:   tdo = read_sr_q[0];
            default:     tdo = 1'b0;
        endcase
    end

    assign count_out = count_q;
    assign local_ack = local_ack_q;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_vjtag_count_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_vjtag_count_sequencer                                        |
// | Brief  : Directed and randomized self-checking bench for the sequencer.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_vjtag_count_sequencer;
    localparam int W = 8;

    logic         tck       = 1'b0;
    logic         aclr      = 1'b0;
    logic         tdi       = 1'b0;
    logic [1:0]   ir_in     = 2'b00;
    logic         v_cdr     = 1'b0;
    logic         v_sdr     = 1'b0;
    logic         v_udr     = 1'b0;
    logic         local_req = 1'b0;
    logic         tdo;
    logic         local_ack;
    logic [W-1:0] count_out;
    logic         busy;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [31:0]  d;
    int           m_count;
    int           m_ovf;

    vjtag_count_sequencer #(.W(W), .FIFO_DEPTH(4)) dut (
        .tck       (tck),
        .aclr      (aclr),
        .tdi       (tdi),
        .ir_in     (ir_in),
        .v_cdr     (v_cdr),
        .v_sdr     (v_sdr),
        .v_udr     (v_udr),
        .local_req (local_req),
        .tdo       (tdo),
        .local_ack (local_ack),
        .count_out (count_out),
        .busy      (busy)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dr_scan(input logic [1:0] ir, input int len, input logic [31:0] din,
                           output logic [31:0] dout);
        dout  = '0;
        ir_in = ir;
        v_cdr = 1'b1;
        tick();
        v_cdr = 1'b0;
        v_sdr = 1'b1;
        for (int i = 0; i < len; i++) begin
            tdi     = din[i];
            dout[i] = tdo;
            tick();
        end
        v_sdr = 1'b0;
        tdi   = 1'b0;
        v_udr = 1'b1;
        tick();
        v_udr = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] arg);
        logic [31:0] unused;
        dr_scan(2'b10, W + 2, {22'd0, op, arg}, unused);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        aclr = 1'b0;
        tick();
        tick();
        aclr = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values, checked while aclr is still low
        tick();
        tick();
        check("rst_count", 32'(count_out), 32'h00);
        check("rst_ack",   32'(local_ack), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_tdo",   32'(tdo),       32'd0);
        aclr = 1'b1;
        tick();

        dr_scan(2'b11, W, 32'd0, d);
        check("readcount_rst", d, 32'h00);
        dr_scan(2'b01, 8, 32'd0, d);
        check("status_rst", d, 32'h01);

        // LOAD latency: new value three cycles after the v_udr cycle
        push_cmd(2'b01, 8'hA5);
        check("load_lat_n1", 32'(count_out), 32'h00);
        tick();
        check("load_lat_n2", 32'(count_out), 32'h00);
        tick();
        check("load_lat_n3", 32'(count_out), 32'hA5);
        dr_scan(2'b11, W, 32'd0, d);
        check("readcount_a5", d, 32'hA5);

        // STEP across the wrap point
        push_cmd(2'b01, 8'hFE);
        wait_idle(50);
        check("load_fe", 32'(count_out), 32'hFE);
        push_cmd(2'b10, 8'd3);
        tick();
        check("step_exec", 32'(count_out), 32'hFE);
        tick();
        check("step_c0", 32'(count_out), 32'hFE);
        tick();
        check("step_c1", 32'(count_out), 32'hFF);
        tick();
        check("step_c2", 32'(count_out), 32'h00);
        tick();
        check("step_c3", 32'(count_out), 32'h01);
        tick();
        check("step_hold", 32'(count_out), 32'h01);
        check("step_busy", 32'(busy), 32'd0);
        dr_scan(2'b01, 8, 32'd0, d);
        check("status_ovf", d, 32'h09);
        dr_scan(2'b01, 8, 32'd0, d);
        check("status_ovf_clr", d, 32'h01);

        // FIFO overflow while a long STEP stalls the sequencer
        push_cmd(2'b10, 8'd200);
        tick();
        tick();
        push_cmd(2'b01, 8'h33);
        push_cmd(2'b00, 8'h00);
        push_cmd(2'b11, 8'h00);
        push_cmd(2'b01, 8'h44);
        push_cmd(2'b10, 8'd2);
        dr_scan(2'b01, 8, 32'd0, d);
        check("status_full_drop", d, 32'h16);
        wait_idle(500);
        check("fifo_final", 32'(count_out), 32'h44);
        dr_scan(2'b01, 8, 32'd0, d);
        check("status_drop_clr", d, 32'h01);

        // Tie between JTAG and LOCAL right after reset: JTAG first
        do_reset();
        push_cmd(2'b01, 8'h10);
        local_req = 1'b1;
        check("tie_n1_cnt", 32'(count_out), 32'h00);
        check("tie_n1_ack", 32'(local_ack), 32'd0);
        tick();
        check("tie_n2_ack", 32'(local_ack), 32'd0);
        tick();
        check("tie_n3_cnt", 32'(count_out), 32'h10);
        check("tie_n3_ack", 32'(local_ack), 32'd0);
        tick();
        check("tie_n4_cnt", 32'(count_out), 32'h11);
        check("tie_n4_ack", 32'(local_ack), 32'd1);
        local_req = 1'b0;
        tick();
        check("tie_n5_cnt", 32'(count_out), 32'h11);
        check("tie_n5_ack", 32'(local_ack), 32'd0);

        // Held local_req: re-granted every other cycle
        local_req = 1'b1;
        tick();
        check("hold_m1_cnt", 32'(count_out), 32'h12);
        check("hold_m1_ack", 32'(local_ack), 32'd1);
        tick();
        check("hold_m2_cnt", 32'(count_out), 32'h12);
        check("hold_m2_ack", 32'(local_ack), 32'd0);
        tick();
        check("hold_m3_cnt", 32'(count_out), 32'h13);
        check("hold_m3_ack", 32'(local_ack), 32'd1);
        local_req = 1'b0;
        tick();
        check("hold_m4_cnt", 32'(count_out), 32'h13);
        check("hold_m4_ack", 32'(local_ack), 32'd0);

        // Asynchronous reset in the middle of a RUN with queued commands
        push_cmd(2'b10, 8'd100);
        tick();
        tick();
        push_cmd(2'b01, 8'h05);
        push_cmd(2'b01, 8'h06);
        check("pre_rst_busy", 32'(busy), 32'd1);
        aclr = 1'b0;
        #1;
        check("arst_count", 32'(count_out), 32'h00);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_ack",   32'(local_ack), 32'd0);
        tick();
        aclr = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("post_rst_count", 32'(count_out), 32'h00);
        check("post_rst_busy",  32'(busy),      32'd0);
        dr_scan(2'b01, 8, 32'd0, d);
        check("post_rst_status", d, 32'h01);

        // Randomized commands and local requests against a transaction model
        m_count = 0;
        m_ovf   = 0;
        for (int it = 0; it < 40; it++) begin
            int          sel;
            logic [7:0]  arg;
            sel = int'($urandom_range(0, 4));
            arg = 8'($urandom_range(0, 255));
            if (sel == 4) begin
                local_req = 1'b1;
                tick();
                local_req = 1'b0;
                tick();
                tick();
                if (m_count == 255) m_ovf = 1;
                m_count = (m_count + 1) % 256;
            end else begin
                if (sel == 2) arg = 8'($urandom_range(0, 40));
                push_cmd(sel[1:0], arg);
                wait_idle(300);
                case (sel)
                    1: m_count = int'(arg);
                    2: begin
                        if (m_count + int'(arg) > 255) m_ovf = 1;
                        m_count = (m_count + int'(arg)) % 256;
                    end
                    3: m_count = 0;
                    default: m_count = m_count;
                endcase
            end
            check("rand_count", 32'(count_out), 32'(m_count));
            if (it % 5 == 4) begin
                dr_scan(2'b01, 8, 32'd0, d);
                check("rand_status", d, 32'(1 + 8 * m_ovf));
                m_ovf = 0;
                dr_scan(2'b11, W, 32'd0, d);
                check("rand_readcount", d, 32'(m_count));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
